// File: rtl/rpn_stack_calculator_if.sv
// Command/display bundle between the debouncer/keypad side and the RPN calculator.
interface rpn_stack_calculator_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             enter;
  logic             is_cmd;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] to_display;
  logic [3:0]       flags;
  logic [DW-1:0]    depth;
  logic             busy;
  logic             error;
  logic [2:0]       cur_state;

  modport master (
    output enter, is_cmd, cmd, data_in,
    input  to_display, flags, depth, busy, error, cur_state
  );
  modport slave (
    input  enter, is_cmd, cmd, data_in,
    output to_display, flags, depth, busy, error, cur_state
  );
endinterface

// File: rtl/rpn_stack_calculator.sv
// Reverse-polish calculator: DEPTH-entry operand stack, 8 commands, {N,Z,C,V} flags.
// Commands are captured in S_IDLE and committed one cycle later in S_EXEC.
module rpn_stack_calculator #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  rpn_stack_calculator_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE = 3'b001, S_EXEC = 3'b010, S_ERROR = 3'b100} state_t;
  typedef enum logic [2:0] {
    C_ADD = 3'b000, C_SUB = 3'b001, C_OR = 3'b010, C_AND = 3'b011,
    C_DUP = 3'b100, C_SWAP = 3'b101, C_DROP = 3'b110, C_CLR = 3'b111
  } cmd_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [DW-1:0]    dep;
  logic [3:0]       flg;
  logic [WIDTH-1:0] a_q, b_q;
  cmd_t             cmd_q, cmd_in;

  logic [IW-1:0]    tos_idx, nos_idx, push_idx;
  logic             full, uf;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] res;
  logic             c_f, v_f;

  assign cmd_in   = cmd_t'(bus.cmd);
  assign full     = (dep == DW'(DEPTH));
  assign tos_idx  = IW'(dep - DW'(1));
  assign nos_idx  = IW'(dep - DW'(2));
  assign push_idx = IW'(dep);

  // Underflow also covers DUP on a full stack, since it would push past DEPTH.
  always_comb begin
    uf = 1'b0;
    case (cmd_in)
      C_ADD, C_SUB, C_OR, C_AND, C_SWAP: uf = (dep < DW'(2));
      C_DUP:                             uf = (dep == '0) || full;
      C_DROP:                            uf = (dep == '0);
      default:                           uf = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (bus.enter) begin
          if (!bus.is_cmd) nxt = full ? S_ERROR : S_IDLE;
          else             nxt = uf   ? S_ERROR : S_EXEC;
        end
      S_EXEC:  nxt = S_IDLE;
      S_ERROR: if (bus.enter) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    dif = {1'b0, a_q} - {1'b0, b_q};
    res = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (cmd_q)
      C_ADD: begin
        res = sum[WIDTH-1:0];
        c_f = sum[WIDTH];
        v_f = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      C_SUB: begin
        res = dif[WIDTH-1:0];
        c_f = ~dif[WIDTH];
        v_f = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      C_OR:    res = a_q | b_q;
      C_AND:   res = a_q & b_q;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      dep   <= '0;
      flg   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cmd_q <= C_CLR;
    end else begin
      case (state)
        S_IDLE:
          if (bus.enter) begin
            if (!bus.is_cmd) begin
              if (!full) begin
                stk[push_idx] <= bus.data_in;
                dep           <= dep + DW'(1);
              end
            end else if (!uf) begin
              a_q   <= stk[nos_idx];
              b_q   <= stk[tos_idx];
              cmd_q <= cmd_in;
            end
          end
        S_EXEC:
          case (cmd_q)
            C_ADD, C_SUB, C_OR, C_AND: begin
              stk[nos_idx] <= res;
              dep          <= dep - DW'(1);
              flg          <= {res[WIDTH-1], (res == '0), c_f, v_f};
            end
            C_DUP: begin
              stk[push_idx] <= b_q;
              dep           <= dep + DW'(1);
            end
            C_SWAP: begin
              stk[tos_idx] <= a_q;
              stk[nos_idx] <= b_q;
            end
            C_DROP: dep <= dep - DW'(1);
            default: begin
              dep <= '0;
              flg <= '0;
            end
          endcase
        default: ;
      endcase
    end
  end

  assign bus.to_display = (dep == '0) ? bus.data_in : stk[tos_idx];
  assign bus.flags      = flg;
  assign bus.depth      = dep;
  assign bus.busy       = (state == S_EXEC);
  assign bus.error      = (state == S_ERROR);
  assign bus.cur_state  = state;
endmodule
